stream_demux_1_to_4: RTL and testbench



---
 rtl/stream_demux_1_to_4.sv | 129 ++++++++++++
 tb/tb_stream_demux_1_to_4.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_to_4.sv
// ---------------------------------------------------------------------------
// stream_demux_1_to_4
//
// Registered 1-to-4 stream demultiplexer. One valid/ready input beat, tagged
// with a 2-bit select, is routed into one of four one-entry output holding
// registers. Each output channel has its own valid/ready handshake, so a
// stalled channel never blocks traffic destined for the other channels.
//
// Parameters:
//   INPUT_BIT_LENGTH : data width per beat (0 is treated as 1), W below
//   CNT_WIDTH        : width of each per-channel transfer counter (stats only)
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_data    in   W      input beat data
//   in_sel     in   2      destination channel: 0=a, 1=b, 2=c, 3=d
//   in_valid   in   1      input beat present
//   in_ready   out  1      selected channel can take a beat this cycle
//   out_data   out  4*W    channel i data in bits [i*W +: W]
//   out_valid  out  4      per-channel beat present
//   out_ready  in   4      per-channel downstream accept
//
// Optional build macro DEMUX_STATS_EN adds:
//   stats_clr  in   1            synchronous clear of all counters
//   out_count  out  4*CNT_WIDTH  saturating handshake count, channel i in
//                                bits [i*CNT_WIDTH +: CNT_WIDTH]
// ---------------------------------------------------------------------------
module stream_demux_1_to_4 #(
    parameter int  INPUT_BIT_LENGTH = 1,
    parameter int  CNT_WIDTH        = 16,
    localparam int W                = (INPUT_BIT_LENGTH < 1) ? 1 : INPUT_BIT_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           in_data,
    input  logic [1:0]             in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [4*W-1:0]         out_data,
    output logic [3:0]             out_valid,
`ifdef DEMUX_STATS_EN
    input  logic                   stats_clr,
    output logic [4*CNT_WIDTH-1:0] out_count,
`endif
    input  logic [3:0]             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    // A channel can take a beat when it is empty or is being drained on the
    // same edge; this gives full throughput of one beat per cycle per channel.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

    logic in_fire;
    assign in_fire = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            chan_state_t    state_reg;
            chan_state_t    state_next;
            logic [W-1:0]   data_reg;
            logic           accept;
            logic           load;

            assign accept = in_fire & (in_sel == 2'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= EMPTY;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    if (load) begin
                        data_reg <= in_data;
                    end
                end
            end

            always_comb begin
                state_next = state_reg;
                load       = 1'b0;
                case (state_reg)
                    EMPTY: begin
                        if (accept) begin
                            state_next = FULL;
                            load       = 1'b1;
                        end
                    end
                    FULL: begin
                        // Accept while FULL only happens when the held beat
                        // is leaving on the same edge: stay FULL, new data.
                        if (accept) begin
                            load = 1'b1;
                        end else if (out_ready[gi]) begin
                            state_next = EMPTY;
                        end
                    end
                    default: state_next = EMPTY;
                endcase
            end

            // Data is left untouched when the channel empties.
            assign out_valid[gi]          = (state_reg == FULL);
            assign out_data[gi*W +: W]    = data_reg;

`ifdef DEMUX_STATS_EN
            logic [CNT_WIDTH-1:0] cnt_reg;

            // Clear wins over a same-edge increment; counting stops at all-ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (stats_clr) begin
                    cnt_reg <= '0;
                end else if (out_valid[gi] && out_ready[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end

            assign out_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_stream_demux_1_to_4.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1_to_4
//
// Bench for stream_demux_1_to_4 (W=1, CNT_WIDTH=2). Inputs are driven 1 ns
// after each rising edge; a negedge monitor keeps one queue per channel,
// pushing beats as they are accepted and popping them when the channel hands
// off, and also tracks the last loaded data and the handshake counters.
// Scenario tasks add their own targeted checks.
// ---------------------------------------------------------------------------
module tb_stream_demux_1_to_4;

    localparam int TB_W   = 1;
    localparam int TB_CW  = 2;
    localparam logic [TB_CW-1:0] CNT_MAX = '1;

    logic                 clk;
    logic                 rst_n;
    logic [TB_W-1:0]      in_data;
    logic [1:0]           in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*TB_W-1:0]    out_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
`ifdef DEMUX_STATS_EN
    logic                 stats_clr;
    logic [4*TB_CW-1:0]   out_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    stream_demux_1_to_4 #(
        .INPUT_BIT_LENGTH (TB_W),
        .CNT_WIDTH        (TB_CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef DEMUX_STATS_EN
        .stats_clr (stats_clr),
        .out_count (out_count),
`endif
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard / reference model ----------------
    logic [TB_W-1:0]  sb_q [4][$];
    logic [TB_W-1:0]  mdata [4];
    logic [TB_CW-1:0] mcnt [4];
    logic [TB_W-1:0]  exp_d;
    logic             exp_rdy;
    logic [3:0]       mhs;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 4; ch++) begin
                sb_q[ch].delete();
                mdata[ch] = '0;
                mcnt[ch]  = '0;
            end
        end else begin
            exp_rdy = (sb_q[in_sel].size() == 0) || out_ready[in_sel];
            for (int ch = 0; ch < 4; ch++) begin
                vectors++;
                if (out_valid[ch] !== (sb_q[ch].size() != 0)) begin
                    miscompares++;
                    $display("FAIL sb_valid ch%0d: got %b expected %b", ch, out_valid[ch], sb_q[ch].size() != 0);
                end
                vectors++;
                if (out_data[ch*TB_W +: TB_W] !== mdata[ch]) begin
                    miscompares++;
                    $display("FAIL sb_data ch%0d: got %h expected %h", ch, out_data[ch*TB_W +: TB_W], mdata[ch]);
                end
`ifdef DEMUX_STATS_EN
                vectors++;
                if (out_count[ch*TB_CW +: TB_CW] !== mcnt[ch]) begin
                    miscompares++;
                    $display("FAIL sb_count ch%0d: got %0d expected %0d", ch, out_count[ch*TB_CW +: TB_CW], mcnt[ch]);
                end
`endif
                mhs[ch] = (sb_q[ch].size() != 0) && out_ready[ch];
                if (mhs[ch]) begin
                    exp_d = sb_q[ch].pop_front();
                    vectors++;
                    if (out_data[ch*TB_W +: TB_W] !== exp_d) begin
                        miscompares++;
                        $display("FAIL sb_handoff ch%0d: got %h expected %h", ch, out_data[ch*TB_W +: TB_W], exp_d);
                    end
                end
`ifdef DEMUX_STATS_EN
                if (stats_clr) mcnt[ch] = '0;
                else if (mhs[ch] && mcnt[ch] != CNT_MAX) mcnt[ch] = mcnt[ch] + 1'b1;
`endif
            end
            if (in_valid) begin
                vectors++;
                if (in_ready !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL sb_in_ready sel%0d: got %b expected %b", in_sel, in_ready, exp_rdy);
                end
                if (exp_rdy) begin
                    sb_q[in_sel].push_back(in_data);
                    mdata[in_sel] = in_data;
                end
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [TB_W-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_sel   = 2'd0;
        in_data  = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            in_sel    = 2'($urandom);
            in_data   = TB_W'($urandom);
            out_ready = 4'($urandom);
            step();
            vectors++;
            if (out_valid !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_valid: got %b expected 0000", out_valid);
            end
            vectors++;
            if (out_data !== '0) begin
                miscompares++;
                $display("FAIL reset_data: got %h expected 0", out_data);
            end
        end
        idle_in();
        out_ready = 4'b0000;
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_in_ready sel%0d: got %b expected 1", s, in_ready);
            end
        end
        in_sel = 2'd0;
        step();
    endtask

    task automatic test_routing();
        logic [3:0] pat;
        pat = 4'b1001;
        out_ready = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            send(2'(s), pat[s]);
            step();
            vectors++;
            if (out_valid !== (4'b0001 << s)) begin
                miscompares++;
                $display("FAIL routing_valid sel%0d: got %b expected %b", s, out_valid, 4'b0001 << s);
            end
            vectors++;
            if (out_data[s] !== pat[s]) begin
                miscompares++;
                $display("FAIL routing_data sel%0d: got %b expected %b", s, out_data[s], pat[s]);
            end
        end
        idle_in();
        step();
        vectors++;
        if (out_data !== 4'b1001) begin
            miscompares++;
            $display("FAIL routing_final: got %b expected 1001", out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b0000;
        send(2'd2, 1'b1);
        step();
        vectors++;
        if (out_valid !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_first: got %b expected 0100", out_valid);
        end
        send(2'd2, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall_ready: got %b expected 0", in_ready);
        end
        step();
        send(2'd1, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_other_ready: got %b expected 1", in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 4'b0110) begin
            miscompares++;
            $display("FAIL bp_isolation_valid: got %b expected 0110", out_valid);
        end
        vectors++;
        if (out_data[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_held_data: got %b expected 1", out_data[2]);
        end
        idle_in();
        out_ready = 4'b1111;
        step();
        vectors++;
        if (out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_drain: got %b expected 0000", out_valid);
        end
    endtask

    task automatic test_drain_accept();
        out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
        stats_clr = 1'b1;
`endif
        send(2'd3, 1'b1);
        step();
`ifdef DEMUX_STATS_EN
        stats_clr = 1'b0;
`endif
        out_ready = 4'b1000;
        send(2'd3, 1'b0);
        step();
        vectors++;
        if (out_valid[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL da_valid: got %b expected 1", out_valid[3]);
        end
        vectors++;
        if (out_data[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL da_data: got %b expected 0", out_data[3]);
        end
`ifdef DEMUX_STATS_EN
        vectors++;
        if (out_count[3*TB_CW +: TB_CW] !== 2'd1) begin
            miscompares++;
            $display("FAIL da_count: got %0d expected 1", out_count[3*TB_CW +: TB_CW]);
        end
`endif
        idle_in();
        out_ready = 4'b1111;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        send(2'd0, 1'b1);
        step();
        send(2'd2, 1'b1);
        step();
        idle_in();
        vectors++;
        if (out_valid !== 4'b0101) begin
            miscompares++;
            $display("FAIL mid_before: got %b expected 0101", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_async_valid: got %b expected 0000", out_valid);
        end
        vectors++;
        if (out_data !== '0) begin
            miscompares++;
            $display("FAIL mid_async_data: got %h expected 0", out_data);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef DEMUX_STATS_EN
    task automatic test_stats();
        out_ready = 4'b1111;
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(2'd1, 1'(i));
            step();
        end
        idle_in();
        step();
        vectors++;
        if (out_count[1*TB_CW +: TB_CW] !== 2'd3) begin
            miscompares++;
            $display("FAIL stats_saturate: got %0d expected 3", out_count[1*TB_CW +: TB_CW]);
        end
        send(2'd1, 1'b1);
        step();
        idle_in();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        vectors++;
        if (out_count[1*TB_CW +: TB_CW] !== 2'd0) begin
            miscompares++;
            $display("FAIL stats_clr_priority: got %0d expected 0", out_count[1*TB_CW +: TB_CW]);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int accepted;
        accepted = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom);
            in_data   = TB_W'($urandom);
            out_ready = 4'($urandom);
            #1;
            if (in_valid && in_ready) accepted++;
            step();
        end
        idle_in();
        out_ready = 4'b1111;
        step();
        step();
        vectors++;
        if (out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL b2b_final_drain: got %b expected 0000", out_valid);
        end
        $display("back_to_back: %0d beats accepted", accepted);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
        stats_clr = 1'b0;
`endif
        idle_in();
        test_reset();
        test_routing();
        test_backpressure();
        test_drain_accept();
        test_reset_mid();
`ifdef DEMUX_STATS_EN
        test_stats();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
